// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: instruction-memory request/response and decode handshake bundle for ifetch_buf
interface ifetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) ();
    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_gnt_i;
    logic              rom_rvalid_i;
    logic [INST_W-1:0] rom_rdata_i;
    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;

    modport master (
        output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  rom_gnt_i, rom_rvalid_i, rom_rdata_i, jump_en_i, jump_addr_i, inst_ready_i
    );

    modport slave (
        input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output rom_gnt_i, rom_rvalid_i, rom_rdata_i, jump_en_i, jump_addr_i, inst_ready_i
    );
endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: PC generator, instruction-memory request port and in-order prefetch FIFO with stall and redirect handling
module ifetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_buf_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [INST_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PTR_W-1:0]  r_head, r_tail, r_fptr;
    logic [CNT_W-1:0]  r_alloc, r_infl, r_drop;

    logic [CNT_W:0]    w_sum;
    logic              w_req, w_alloc, w_drop, w_fill, w_valid, w_pop;

    // Responses still owed to flushed fetches occupy slots until they return
    assign w_sum   = {1'b0, r_alloc} + {1'b0, r_drop};
    assign w_req   = rst_n && !bus.jump_en_i && (w_sum < (CNT_W+1)'(DEPTH));
    assign w_alloc = w_req && bus.rom_gnt_i;
    assign w_drop  = bus.rom_rvalid_i && (r_drop != '0);
    assign w_fill  = bus.rom_rvalid_i && (r_drop == '0) && (r_infl != '0);
    assign w_valid = (r_alloc != '0) && r_filled[r_head];
    assign w_pop   = w_valid && bus.inst_ready_i;

    assign bus.rom_req_o    = w_req;
    assign bus.rom_addr_o   = r_pc;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? r_data[r_head] : '0;
    assign bus.inst_addr_o  = w_valid ? r_addr[r_head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_head   <= '0;
            r_tail   <= '0;
            r_fptr   <= '0;
            r_filled <= '0;
            r_alloc  <= '0;
            r_infl   <= '0;
            r_drop   <= '0;
        end else if (bus.jump_en_i) begin
            r_pc     <= bus.jump_addr_i;
            r_head   <= '0;
            r_tail   <= '0;
            r_fptr   <= '0;
            r_filled <= '0;
            r_alloc  <= '0;
            r_infl   <= '0;
            r_drop   <= r_drop + r_infl - CNT_W'(w_drop | w_fill);
        end else begin
            if (w_alloc) begin
                r_pc             <= r_pc + PC_STEP;
                r_tail           <= r_tail + PTR_W'(1);
                r_filled[r_tail] <= 1'b0;
            end
            if (w_fill) begin
                r_fptr           <= r_fptr + PTR_W'(1);
                r_filled[r_fptr] <= 1'b1;
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (w_drop)
                r_drop <= r_drop - CNT_W'(1);
            r_alloc <= r_alloc + CNT_W'(w_alloc) - CNT_W'(w_pop);
            r_infl  <= r_infl + CNT_W'(w_alloc) - CNT_W'(w_fill);
        end
    end

    // Payload storage needs no reset: validity is carried by r_filled and r_alloc
    always_ff @(posedge clk) begin
        if (w_alloc)
            r_addr[r_tail] <= r_pc;
        if (w_fill)
            r_data[r_fptr] <= bus.rom_rdata_i;
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed bench for ifetch_buf against a queue-based reference model and in-order memory responder
module tb_ifetch_buf;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        f;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch_buf_if #(.ADDR_W(32), .INST_W(32)) bus ();

    ifetch_buf #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc, t_gnt, t_val, grants;
    logic [31:0] log_q[$];
    logic [31:0] pend[$];
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_drop;
    logic        rv_en;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'd3) + 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One cycle: drive inputs at the negedge, compare against the model, then advance the model across the posedge
    task automatic step(input logic jmp, input logic [31:0] ja, input logic rdy, input logic g, input logic force_rv);
        logic        rv, e_req, e_val, found;
        logic [31:0] rd, e_inst, e_addr;
        int          infl;
        rv = (rv_en && pend.size() > 0) || force_rv;
        rd = (rv_en && pend.size() > 0) ? mem(pend[0]) : 32'hDEAD_BEEF;
        bus.jump_en_i    = jmp;
        bus.jump_addr_i  = ja;
        bus.inst_ready_i = rdy;
        bus.rom_gnt_i    = g;
        bus.rom_rvalid_i = rv;
        bus.rom_rdata_i  = rd;
        #1;
        e_req  = !jmp && (q.size() + m_drop < 4);
        e_val  = q.size() > 0 && q[0].f;
        e_inst = e_val ? q[0].d : 32'h0;
        e_addr = e_val ? q[0].a : 32'h0;
        chk("rom_req", {31'b0, bus.rom_req_o}, {31'b0, e_req});
        chk("rom_addr", bus.rom_addr_o, m_pc);
        chk("inst_valid", {31'b0, bus.inst_valid_o}, {31'b0, e_val});
        chk("inst", bus.inst_o, e_inst);
        chk("inst_addr", bus.inst_addr_o, e_addr);
        if (bus.inst_valid_o && rdy) log_q.push_back(bus.inst_addr_o);
        if (e_req && g) begin
            grants++;
            if (t_gnt < 0) t_gnt = cyc;
        end
        if (e_val && t_val < 0) t_val = cyc;
        if (rv_en && pend.size() > 0) void'(pend.pop_front());
        if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
                found = 1'b0;
                foreach (q[i]) if (!found && !q[i].f) begin
                    q[i].d = rd;
                    q[i].f = 1'b1;
                    found = 1'b1;
                end
            end
        end
        if (e_val && rdy) void'(q.pop_front());
        if (e_req && g) begin
            q.push_back('{a: m_pc, d: 32'h0, f: 1'b0});
            pend.push_back(m_pc);
            m_pc += 32'd4;
        end
        if (jmp) begin
            infl = 0;
            foreach (q[i]) if (!q[i].f) infl++;
            m_drop += infl;
            q.delete();
            m_pc = ja;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        bus.jump_en_i    = 1'b0;
        bus.jump_addr_i  = 32'h0;
        bus.inst_ready_i = 1'b0;
        bus.rom_gnt_i    = 1'b0;
        bus.rom_rvalid_i = 1'b0;
        bus.rom_rdata_i  = 32'h0;
        #1;
        chk("rst_req", {31'b0, bus.rom_req_o}, 32'h0);
        chk("rst_addr", bus.rom_addr_o, 32'h0);
        chk("rst_valid", {31'b0, bus.inst_valid_o}, 32'h0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_inst_addr", bus.inst_addr_o, 32'h0);
        q.delete();
        pend.delete();
        log_q.delete();
        m_pc = 32'h0;
        m_drop = 0;
        grants = 0;
        t_gnt = -1;
        t_val = -1;
        cyc = 0;
        rv_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] e2[5];
        int bad;
        bus.jump_en_i = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.inst_ready_i = 1'b0;
        bus.rom_gnt_i = 1'b0;
        bus.rom_rvalid_i = 1'b0;
        bus.rom_rdata_i = 32'h0;
        @(negedge clk);

        // 1: streaming fetch
        apply_reset();
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t1_latency", t_val - t_gnt, 32'd2);
        chk("t1_count", log_q.size(), 32'd6);
        chk("t1_a1", log_q[1], 32'h4);
        chk("t1_a2", log_q[2], 32'h8);

        // 2: backpressure fills four slots, then drains in order
        apply_reset();
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t2_grants", grants, 32'd4);
        chk("t2_req_off", {31'b0, bus.rom_req_o}, 32'h0);
        log_q.delete();
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        e2 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        foreach (e2[i]) chk("t2_order", log_q[i], e2[i]);

        // 3: redirect with two fetches in flight
        apply_reset();
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        rv_en = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
        rv_en = 1'b1;
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t3_a0", log_q[0], 32'h0);
        chk("t3_a1", log_q[1], 32'h4);
        chk("t3_a2", log_q[2], 32'h100);
        chk("t3_a3", log_q[3], 32'h104);
        bad = 0;
        foreach (log_q[i]) if (log_q[i] == 32'h8 || log_q[i] == 32'hC) bad++;
        chk("t3_no_stale", bad, 32'd0);

        // 4: grant withheld for five cycles
        apply_reset();
        repeat (5) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("t4_addr_hold", bus.rom_addr_o, 32'h0);
            chk("t4_req_hold", {31'b0, bus.rom_req_o}, 32'h1);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t4_pc_step", bus.rom_addr_o, 32'h4);
        chk("t4_grants", grants, 32'd1);

        // 5: redirect coinciding with a head pop and a response
        apply_reset();
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rv_en = 1'b0;
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        rv_en = 1'b1;
        step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t5_a0", log_q[0], 32'h0);
        chk("t5_a1", log_q[1], 32'h200);
        chk("t5_a2", log_q[2], 32'h204);
        bad = 0;
        foreach (log_q[i]) if (log_q[i] == 32'h0 || log_q[i] == 32'h4) bad++;
        chk("t5_once", bad, 32'd1);

        // 6: reset with a full FIFO and a response outstanding
        apply_reset();
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t6_full_valid", {31'b0, bus.inst_valid_o}, 32'h1);
        apply_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("t6_a0", log_q[0], 32'h0);
        chk("t6_a1", log_q[1], 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
